// File: rtl/mul32_seq_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
// The master issues operations and the slave (the multiplier) returns results.
interface mul32_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 sign_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, sign_mode, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, sign_mode, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/mul32_seq.sv
// Sequential shift-add multiplier: multiplies operand magnitudes over WIDTH
// cycles, then applies the sign in a final FIX cycle. Unsigned or signed per op.
module mul32_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mul32_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  neg_q, neg_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    product_q, product_d;
  logic                  done_q, done_d;

  // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] val,
                                                 input logic             sgn);
    if (sgn && val[WIDTH-1]) return (~val) + WIDTH'(1);
    return val;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic               neg);
    if (neg) return (~mag) + (2*WIDTH)'(1);
    return mag;
  endfunction

  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = magnitude(bus.multiplicand, bus.sign_mode);
          mplier_d = magnitude(bus.multiplier, bus.sign_mode);
          neg_d    = bus.sign_mode &
                     (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        product_d = apply_sign(acc_q, neg_q);
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule
